// File: rtl/power_detect_chain.sv
// Windowed I/Q power detector: passthrough, power-sum or peak-hold over a programmable
// number of samples, with a 4-stage power pipeline and a settings-bus register bank.
module power_detect_chain #(
  parameter int BASE      = 0,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             run,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             strobe_in,
  output logic [31:0]      sample_out,
  output logic             strobe_out,
  output logic             overflow
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [7:0] ADDR_LEN   = 8'(BASE);
  localparam logic [7:0] ADDR_MODE  = 8'(BASE + 1);
  localparam logic [7:0] ADDR_SHIFT = 8'(BASE + 2);

  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [1:0]           mode_q, mode_d;
  logic [5:0]           shift_q, shift_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0]     i1_q, i1_d, q1_q, q1_d;
  logic [2*WIDTH-1:0]   ii_q, ii_d, qq_q, qq_d;
  logic [PW-1:0]        p_q, p_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 flag_q, flag_d;
  logic [31:0]          sample_out_q, sample_out_d;
  logic                 strobe_out_q, strobe_out_d;
  logic                 overflow_q, overflow_d;

  logic                   wr_len, wr_mode, wr_shift, flush, power_mode;
  logic [LEN_WIDTH-1:0]   len_last;
  logic signed [2*WIDTH-1:0] i1_sx, q1_sx;
  logic [ACC_WIDTH-1:0]   p_ext, acc_new, shifted;
  logic [ACC_WIDTH:0]     sum;
  logic                   flag_new, dump_sat;
  logic                   unused_set_bits;

  assign unused_set_bits = ^set_data;

  always_comb begin
    wr_len     = set_stb && (set_addr == ADDR_LEN);
    wr_mode    = set_stb && (set_addr == ADDR_MODE);
    wr_shift   = set_stb && (set_addr == ADDR_SHIFT);
    // Any settings write restarts the window so old and new settings never mix.
    flush      = !run || clr || wr_len || wr_mode || wr_shift;
    power_mode = (mode_q == 2'd1) || (mode_q == 2'd2);
    len_last   = (len_q == '0) ? '0 : len_q - 1'b1;

    i1_sx = {{WIDTH{i1_q[WIDTH-1]}}, i1_q};
    q1_sx = {{WIDTH{q1_q[WIDTH-1]}}, q1_q};

    p_ext    = ACC_WIDTH'(p_q);
    sum      = {1'b0, acc_q} + {1'b0, p_ext};
    acc_new  = sum[ACC_WIDTH-1:0];
    flag_new = flag_q;
    if (mode_q == 2'd2) begin
      acc_new = (p_ext > acc_q) ? p_ext : acc_q;
    end else if (sum[ACC_WIDTH]) begin
      acc_new  = '1;
      flag_new = 1'b1;
    end
    shifted  = acc_new >> shift_q;
    // A saturated accumulator is only a lower bound, so the window reports full scale.
    dump_sat = flag_new || (|shifted[ACC_WIDTH-1:32]);

    len_d        = len_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    i1_d         = i_in;
    q1_d         = q_in;
    ii_d         = i1_sx * i1_sx;
    qq_d         = q1_sx * q1_sx;
    p_d          = {1'b0, ii_q} + {1'b0, qq_q};
    v1_d         = strobe_in && power_mode;
    v2_d         = v1_q;
    v3_d         = v2_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    flag_d       = flag_q;
    sample_out_d = sample_out_q;
    strobe_out_d = 1'b0;
    overflow_d   = overflow_q;

    if (v3_q) begin
      if (cnt_q == len_last) begin
        sample_out_d = dump_sat ? 32'hFFFF_FFFF : shifted[31:0];
        overflow_d   = dump_sat;
        strobe_out_d = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        flag_d       = 1'b0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        acc_d  = acc_new;
        flag_d = flag_new;
      end
    end

    if (strobe_in && !power_mode) begin
      sample_out_d = {i_in[WIDTH-1 -: 16], q_in[WIDTH-1 -: 16]};
      overflow_d   = 1'b0;
      strobe_out_d = 1'b1;
    end

    if (flush) begin
      v1_d         = 1'b0;
      v2_d         = 1'b0;
      v3_d         = 1'b0;
      cnt_d        = '0;
      acc_d        = '0;
      flag_d       = 1'b0;
      sample_out_d = sample_out_q;
      overflow_d   = overflow_q;
      strobe_out_d = 1'b0;
    end

    if (wr_len)   len_d   = set_data[LEN_WIDTH-1:0];
    if (wr_mode)  mode_d  = set_data[1:0];
    if (wr_shift) shift_d = set_data[5:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q        <= '0;
      mode_q       <= '0;
      shift_q      <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      i1_q         <= '0;
      q1_q         <= '0;
      ii_q         <= '0;
      qq_q         <= '0;
      p_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      flag_q       <= 1'b0;
      sample_out_q <= '0;
      strobe_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      len_q        <= len_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      i1_q         <= i1_d;
      q1_q         <= q1_d;
      ii_q         <= ii_d;
      qq_q         <= qq_d;
      p_q          <= p_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      flag_q       <= flag_d;
      sample_out_q <= sample_out_d;
      strobe_out_q <= strobe_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sample_out = sample_out_q;
  assign strobe_out = strobe_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_power_detect_chain.sv
// Bench for power_detect_chain: default instance plus an ACC_WIDTH=33 instance on shared
// inputs, each checked against its own expected queue of {overflow, sample_out} and cycle.
module tb_power_detect_chain;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        run;
  logic [15:0] i_in;
  logic [15:0] q_in;
  logic        strobe_in;
  logic [31:0] sample_out, sample_out_s;
  logic        strobe_out, strobe_out_s;
  logic        overflow, overflow_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [32:0] exp_sat_q[$];
  int          exp_sat_cyc_q[$];
  logic [63:0] win_p[$];

  logic [1:0]  mode_m;
  logic [5:0]  shift_m;
  int          len_m;

  power_detect_chain dut (
    .clk(clk), .rst(rst), .clr(clr), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .run(run), .i_in(i_in), .q_in(q_in), .strobe_in(strobe_in),
    .sample_out(sample_out), .strobe_out(strobe_out), .overflow(overflow)
  );

  power_detect_chain #(.ACC_WIDTH(33)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .run(run), .i_in(i_in), .q_in(q_in), .strobe_in(strobe_in),
    .sample_out(sample_out_s), .strobe_out(strobe_out_s), .overflow(overflow_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [32:0] model_dump(input int aw, input logic [1:0] m,
                                             input logic [5:0] sh);
    logic [63:0] acc = 64'd0;
    logic [63:0] lim;
    logic [63:0] s;
    bit          flag = 1'b0;
    lim = (64'd1 << aw) - 64'd1;
    foreach (win_p[k]) begin
      if (m == 2'd2) begin
        if (win_p[k] > acc) acc = win_p[k];
      end else if (acc + win_p[k] > lim) begin
        acc  = lim;
        flag = 1'b1;
      end else begin
        acc = acc + win_p[k];
      end
    end
    s = acc >> sh;
    if (flag || s > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, s[31:0]};
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      strobe_in = 1'b0; set_stb = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic drive_sample(input int i, input int q);
    logic [63:0] p;
    logic [31:0] iv, qv;
    int          len_eff;
    @(posedge clk); #1;
    set_stb = 1'b0; clr = 1'b0;
    i_in = 16'(i); q_in = 16'(q); strobe_in = 1'b1;
    iv = 32'(i); qv = 32'(q);
    if (mode_m == 2'd1 || mode_m == 2'd2) begin
      p = 64'(longint'(i) * longint'(i) + longint'(q) * longint'(q));
      win_p.push_back(p);
      len_eff = (len_m == 0) ? 1 : len_m;
      if (win_p.size() == len_eff) begin
        exp_q.push_back(model_dump(48, mode_m, shift_m));
        exp_cyc_q.push_back(cyc + 4);
        exp_sat_q.push_back(model_dump(33, mode_m, shift_m));
        exp_sat_cyc_q.push_back(cyc + 4);
        win_p.delete();
      end
    end else begin
      exp_q.push_back({1'b0, iv[15:0], qv[15:0]});
      exp_cyc_q.push_back(cyc + 1);
      exp_sat_q.push_back({1'b0, iv[15:0], qv[15:0]});
      exp_sat_cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic write_reg(input int addr, input int data);
    @(posedge clk); #1;
    strobe_in = 1'b0; clr = 1'b0;
    set_stb = 1'b1; set_addr = 8'(addr); set_data = 32'(data);
    case (addr)
      0: len_m = data & 16'hFFFF;
      1: mode_m = 2'(data);
      2: shift_m = 6'(data);
      default: ;
    endcase
    if (addr <= 2) win_p.delete();
  endtask

  task automatic set_run(input logic v);
    @(posedge clk); #1;
    strobe_in = 1'b0; set_stb = 1'b0; clr = 1'b0;
    run = v;
    if (!v) win_p.delete();
  endtask

  task automatic clr_with_strobe(input int i, input int q);
    @(posedge clk); #1;
    set_stb = 1'b0; clr = 1'b1;
    i_in = 16'(i); q_in = 16'(q); strobe_in = 1'b1;
    win_p.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample_out"}, sample_out, 0);
    check({tag, "_strobe_out"}, strobe_out, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_sat_sample_out"}, sample_out_s, 0);
    check({tag, "_sat_strobe_out"}, strobe_out_s, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    strobe_in = 1'b0; set_stb = 1'b0; clr = 1'b0;
    rst = 1'b0;
    mode_m = 2'd0; shift_m = 6'd0; len_m = 0;
    win_p.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // scoreboard
  always @(negedge clk) begin : scoreboard
    logic [32:0] e;
    int          c;
    if (strobe_out) begin
      if (exp_q.size() == 0) check("spurious_strobe", 1, 0);
      else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("sample_out", sample_out, e[31:0]);
        check("overflow", overflow, e[32]);
        check("latency", cyc, c);
      end
    end
    if (strobe_out_s) begin
      if (exp_sat_q.size() == 0) check("sat_spurious_strobe", 1, 0);
      else begin
        e = exp_sat_q.pop_front();
        c = exp_sat_cyc_q.pop_front();
        check("sat_sample_out", sample_out_s, e[31:0]);
        check("sat_overflow", overflow_s, e[32]);
        check("sat_latency", cyc, c);
      end
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    run = 1'b0; i_in = '0; q_in = '0; strobe_in = 1'b0;
    mode_m = 2'd0; shift_m = 6'd0; len_m = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    set_run(1'b1);

    // passthrough, mode 0 then mode 3
    drive_sample(32'h1234, 32'hABCD);
    idle(3);
    write_reg(1, 3);
    drive_sample(-5, 32'h7FFF);
    drive_sample(32'h8000, 1);
    idle(3);

    // power sum: 4 x (3,4) -> 100
    write_reg(0, 4);
    write_reg(1, 1);
    write_reg(2, 0);
    repeat (4) drive_sample(3, 4);
    idle(6);

    // peak hold -> 100
    write_reg(1, 2);
    drive_sample(1, 0); drive_sample(3, 0); drive_sample(6, 8); drive_sample(2, 0);
    idle(6);

    // saturation, then outputs hold between strobes
    write_reg(1, 1);
    write_reg(0, 8);
    write_reg(2, 2);
    repeat (8) drive_sample(-32768, -32768);
    idle(6);
    @(negedge clk);
    check("hold_sample_out", sample_out, 32'hFFFF_FFFF);
    check("hold_overflow", overflow, 1);
    check("hold_sat_sample_out", sample_out_s, 32'hFFFF_FFFF);
    check("hold_sat_overflow", overflow_s, 1);

    // restart: 5 strobes with len 3, run drop discards the partial window
    write_reg(0, 3);
    write_reg(2, 0);
    repeat (5) drive_sample(3, 4);
    idle(6);
    set_run(1'b0);
    idle(3);
    set_run(1'b1);
    repeat (3) drive_sample(3, 4);
    idle(6);

    // mid-window settings write drops the first two samples
    write_reg(0, 4);
    repeat (2) drive_sample(3, 4);
    write_reg(2, 0);
    repeat (4) drive_sample(3, 4);
    idle(6);

    // a write to an address outside the bank leaves the window intact
    repeat (2) drive_sample(1, 1);
    write_reg(3, 5);
    repeat (2) drive_sample(1, 1);
    idle(6);

    // clr beats strobe_in; len=0 acts as len=1
    write_reg(0, 0);
    clr_with_strobe(5, 5);
    drive_sample(2, 2);
    idle(6);

    // randomized windows
    for (int r = 0; r < 4; r++) begin
      int ln, n;
      ln = $urandom_range(1, 4);
      write_reg(1, $urandom_range(1, 2));
      write_reg(0, ln);
      write_reg(2, $urandom_range(0, 3));
      n = 2 * ln + $urandom_range(0, ln - 1);
      for (int k = 0; k < n; k++) begin
        drive_sample(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(6);
    end

    // reset mid-window produces nothing; block comes back in passthrough
    write_reg(1, 1);
    write_reg(0, 4);
    repeat (2) drive_sample(3, 4);
    pulse_reset();
    idle(6);
    drive_sample(32'h55AA, 32'h0F0F);
    idle(4);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_sat_q_drained", exp_sat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/power_detect_chain.md
POWER_DETECT_CHAIN -- requirements
Module: power_detect_chain

Interface
REQ-001 Parameter BASE, default 0: settings address of the first register; registers occupy BASE..BASE+2.
REQ-002 Parameter WIDTH, default 16: I/Q component width, two's complement; SHALL be at least 16.
REQ-003 Parameter ACC_WIDTH, default 48: power accumulator width; SHALL be at least 2*WIDTH+1.
REQ-004 Parameter LEN_WIDTH, default 16: integration-length register width.
REQ-005 clk  in  1  single clock; every register is clocked on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 clr  in  1  synchronous flush of the window and the pipeline.
REQ-008 set_stb  in  1  settings write strobe.
REQ-009 set_addr  in  8  settings address.
REQ-010 set_data  in  32  settings data.
REQ-011 run  in  1  enable; low holds the block idle.
REQ-012 i_in, q_in  in  WIDTH each  input sample components.
REQ-013 strobe_in  in  1  input sample valid for one cycle.
REQ-014 sample_out  out  32  result word.
REQ-015 strobe_out  out  1  one-cycle pulse marking a valid sample_out.
REQ-016 overflow  out  1  saturation flag for the window just output.

Function
REQ-017 Register BASE+0: len = set_data[LEN_WIDTH-1:0], the samples per window; len=0 SHALL behave as len=1.
REQ-018 Register BASE+1: mode = set_data[1:0]: 0 passthrough, 1 power sum, 2 peak hold, 3 same as 0.
REQ-019 Register BASE+2: shift = set_data[5:0], the right shift applied to the power result.
REQ-020 A write to any of the three registers SHALL clear the sample counter and the accumulator, and SHALL invalidate in-flight pipeline samples, on the cycle after the write.
REQ-021 Passthrough mode: on strobe_in, the next cycle SHALL give sample_out = {i_in[WIDTH-1 -:16], q_in[WIDTH-1 -:16]} and strobe_out=1, with overflow=0.
REQ-022 Power pipeline, stage 1: register i, q and the valid bit.
REQ-023 Power pipeline, stage 2: form i*i and q*q, each 2*WIDTH bits unsigned.
REQ-024 Power pipeline, stage 3: p = i*i + q*q, 2*WIDTH+1 bits.
REQ-025 Power pipeline, stage 4: accumulate p.
REQ-026 Mode 1: the accumulator adds p and saturates at 2^ACC_WIDTH-1; saturation sets a sticky per-window overflow bit.
REQ-027 Mode 2: the accumulator takes max(acc, p) per sample and never overflows.
REQ-028 Window: a counter counts the valid p values; on the len-th value the block SHALL dump and restart.
REQ-029 Dump value: sample_out = (final acc including that p) >> shift, saturated to 0xFFFFFFFF if it exceeds 32 bits; that saturation also sets overflow.
REQ-030 On a dump, strobe_out SHALL pulse and overflow SHALL equal the window flag.
REQ-031 On the same cycle as a dump, the counter, the accumulator and the flag SHALL restart at zero, so that no sample is lost.
REQ-032 Power-mode latency: strobe_out SHALL assert exactly 4 cycles after the strobe_in of the last sample in the window.
REQ-033 Input acceptance: strobe_in may be asserted on every cycle; back-to-back samples SHALL all be accepted.
REQ-034 run=0 or clr=1: the pipeline valid bits, the counter, the accumulator and the flag SHALL clear synchronously, and strobe_out SHALL be held at 0.
REQ-035 Partial windows SHALL be discarded; the first window after run rises starts at count 0.
REQ-036 Between strobes, sample_out and overflow SHALL hold their last values.
REQ-037 clr SHALL take priority over strobe_in in the same cycle, and a settings write SHALL also take priority over strobe_in.

Reset
REQ-038 When rst is low, all state SHALL clear asynchronously: sample_out=0, strobe_out=0, overflow=0, len=0, mode=0, shift=0, counter=0, accumulator=0, all valid bits=0.
REQ-039 After release of rst, the first strobe_out SHALL require a full new window; reset asserted mid-window SHALL produce no output from that window.

Verification
REQ-040 Mode 0 sample: i_in=0x1234, q_in=0xABCD with a strobe_in -> sample_out=0x1234ABCD and strobe_out=1 one cycle later.
REQ-041 Mode 1 sum: len=4, shift=0, four strobes of i=3, q=4 -> a single strobe_out 4 cycles after the 4th strobe, sample_out=100, overflow=0.
REQ-042 Mode 2 peak: len=4, (i,q) = (1,0), (3,0), (6,8), (2,0) -> sample_out=100.
REQ-043 Mode 1 saturation: ACC_WIDTH=33 instance, len=8, shift=2, i=q=-32768 on every strobe -> sample_out=0xFFFFFFFF, overflow=1.
REQ-044 Mode 1 restart: len=3 with 5 consecutive strobes of p=25, then run dropped low -> one output of 75 and no second strobe.
REQ-045 Mode 1 restart, continued: after run rises again, 3 more strobes -> sample_out=75.
REQ-046 Mid-window write: len=4, two strobes, a write to shift, then four strobes -> exactly one strobe_out, covering only the last four samples.
